// File: rtl/regfile_sync_read.sv
// rtl/regfile_sync_read.sv - 32-entry register file with hardwired-zero register and registered dual read ports
// Optional macro REGFILE_BYPASS_EN: same-edge write data is forwarded to a read of the same address.
module regfile_sync_read #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWrite,
    input  logic [4:0]       WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    input  logic             ReadEn,
    input  logic [4:0]       ReadRegister1,
    input  logic [4:0]       ReadRegister2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2,
    output logic             ReadValid
);

    localparam logic [4:0] ZERO_ADDR = 5'(ZERO_REG);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] rd1_d;
    logic [WIDTH-1:0] rd1_q;
    logic [WIDTH-1:0] rd2_d;
    logic [WIDTH-1:0] rd2_q;
    logic             valid_q;
    logic             wr_en;

    assign wr_en = RegWrite && (WriteRegister != ZERO_ADDR);

    // The zero register is masked on read as well, so it reads 0 regardless of array contents.
    always_comb begin
        rd1_d = (ReadRegister1 == ZERO_ADDR) ? '0 : regs_q[ReadRegister1];
        rd2_d = (ReadRegister2 == ZERO_ADDR) ? '0 : regs_q[ReadRegister2];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (WriteRegister == ReadRegister1)) rd1_d = WriteData;
        if (wr_en && (WriteRegister == ReadRegister2)) rd2_d = WriteData;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            if (wr_en) regs_q[WriteRegister] <= WriteData;
            if (ReadEn) begin
                rd1_q <= rd1_d;
                rd2_q <= rd2_d;
            end
            valid_q <= ReadEn;
        end
    end

    assign ReadData1 = rd1_q;
    assign ReadData2 = rd2_q;
    assign ReadValid = valid_q;

endmodule

// File: tb/tb_regfile_sync_read.sv
// tb/tb_regfile_sync_read.sv - directed and randomized checks of regfile_sync_read against an array model
module tb_regfile_sync_read;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        RegWrite = 1'b0;
    logic [4:0]  WriteRegister = '0;
    logic [63:0] WriteData = '0;
    logic        ReadEn = 1'b0;
    logic [4:0]  ReadRegister1 = '0;
    logic [4:0]  ReadRegister2 = '0;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;
    logic        ReadValid;

    int checks = 0;
    int errors = 0;

    logic [63:0] m_regs [32];
    logic [63:0] exp_rd1 = '0;
    logic [63:0] exp_rd2 = '0;
    logic        exp_valid = 1'b0;

    regfile_sync_read dut (
        .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
        .WriteData(WriteData), .ReadEn(ReadEn), .ReadRegister1(ReadRegister1),
        .ReadRegister2(ReadRegister2), .ReadData1(ReadData1), .ReadData2(ReadData2),
        .ReadValid(ReadValid)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model_read(input logic [4:0] addr);
        if (addr == 5'd31) return 64'd0;
`ifdef REGFILE_BYPASS_EN
        if (RegWrite && WriteRegister == addr) return WriteData;
`endif
        return m_regs[addr];
    endfunction

    // Advances the model by one edge from the currently driven inputs, then waits past the DUT edge.
    task automatic clk_edge();
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            exp_rd1 = '0;
            exp_rd2 = '0;
            exp_valid = 1'b0;
        end else begin
            if (ReadEn) begin
                exp_rd1 = model_read(ReadRegister1);
                exp_rd2 = model_read(ReadRegister2);
            end
            exp_valid = ReadEn;
            if (RegWrite && WriteRegister != 5'd31) m_regs[WriteRegister] = WriteData;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; RegWrite = 1'b0; ReadEn = 1'b0;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [63:0] d);
        idle(); RegWrite = 1'b1; WriteRegister = a; WriteData = d;
        clk_edge();
    endtask

    task automatic do_read(input logic [4:0] a1, input logic [4:0] a2);
        idle(); ReadEn = 1'b1; ReadRegister1 = a1; ReadRegister2 = a2;
        clk_edge();
    endtask

    task automatic test_reset();
        reset = 1'b1; RegWrite = 1'b1; WriteRegister = 5'd2; WriteData = 64'h1234;
        ReadEn = 1'b1; ReadRegister1 = 5'd2; ReadRegister2 = 5'd3;
        clk_edge();
        clk_edge();
        checks++;
        if (ReadData1 !== 64'd0 || ReadData2 !== 64'd0 || ReadValid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state rd1=%h rd2=%h valid=%b expected 0 0 0", ReadData1, ReadData2, ReadValid);
        end
        do_read(5'd5, 5'd31);
        checks++;
        if (ReadData1 !== 64'd0 || ReadData2 !== 64'd0 || ReadValid !== 1'b1) begin
            errors++;
            $display("FAIL reset_read rd1=%h rd2=%h valid=%b expected 0 0 1", ReadData1, ReadData2, ReadValid);
        end
        idle();
        clk_edge();
        checks++;
        if (ReadValid !== 1'b0) begin
            errors++;
            $display("FAIL valid_one_cycle valid=%b expected 0", ReadValid);
        end
    endtask

    task automatic test_write_read();
        do_write(5'd7, 64'h0123456789ABCDEF);
        do_read(5'd7, 5'd7);
        checks++;
        if (ReadData1 !== 64'h0123456789ABCDEF || ReadData2 !== 64'h0123456789ABCDEF || ReadValid !== 1'b1) begin
            errors++;
            $display("FAIL write_read rd1=%h rd2=%h valid=%b expected 0123456789abcdef both, 1", ReadData1, ReadData2, ReadValid);
        end
    endtask

    task automatic test_zero_reg();
        do_write(5'd31, 64'hFFFFFFFFFFFFFFFF);
        do_read(5'd31, 5'd7);
        checks++;
        if (ReadData1 !== 64'd0 || ReadData2 !== 64'h0123456789ABCDEF) begin
            errors++;
            $display("FAIL zero_reg rd1=%h rd2=%h expected 0 0123456789abcdef", ReadData1, ReadData2);
        end
    endtask

    task automatic test_same_edge();
        logic [63:0] want;
        do_write(5'd3, 64'hA);
        idle(); RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 64'hB;
        ReadEn = 1'b1; ReadRegister1 = 5'd3; ReadRegister2 = 5'd3;
        clk_edge();
`ifdef REGFILE_BYPASS_EN
        want = 64'hB;
`else
        want = 64'hA;
`endif
        checks++;
        if (ReadData1 !== want || ReadData2 !== want) begin
            errors++;
            $display("FAIL same_edge rd1=%h rd2=%h expected %h", ReadData1, ReadData2, want);
        end
        do_read(5'd3, 5'd31);
        checks++;
        if (ReadData1 !== 64'hB || ReadData2 !== 64'd0) begin
            errors++;
            $display("FAIL same_edge_later rd1=%h rd2=%h expected b 0", ReadData1, ReadData2);
        end
    endtask

    task automatic test_hold();
        do_write(5'd4, 64'h55);
        do_read(5'd4, 5'd4);
        for (int i = 0; i < 3; i++) begin
            idle(); RegWrite = 1'b1; WriteRegister = 5'd4; WriteData = 64'h66;
            clk_edge();
            checks++;
            if (ReadData1 !== 64'h55 || ReadValid !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d] rd1=%h valid=%b expected 55 0", i, ReadData1, ReadValid);
            end
        end
        do_read(5'd4, 5'd4);
        checks++;
        if (ReadData2 !== 64'h66) begin
            errors++;
            $display("FAIL hold_after rd2=%h expected 66", ReadData2);
        end
    endtask

    task automatic test_back_to_back();
        do_write(5'd10, 64'hAAAA_0000_1111_2222);
        do_write(5'd10, 64'hBBBB_3333_4444_5555);
        for (int i = 0; i < 3; i++) begin
            do_read(5'd10, 5'd7);
            checks++;
            if (ReadData1 !== 64'hBBBB_3333_4444_5555 || ReadData2 !== 64'h0123456789ABCDEF || ReadValid !== 1'b1) begin
                errors++;
                $display("FAIL back_to_back[%0d] rd1=%h rd2=%h valid=%b expected bbbb333344445555 0123456789abcdef 1",
                         i, ReadData1, ReadData2, ReadValid);
            end
        end
    endtask

    task automatic test_reset_midstream();
        do_read(5'd7, 5'd10);
        idle(); reset = 1'b1; RegWrite = 1'b1; WriteRegister = 5'd2; WriteData = 64'h99;
        clk_edge();
        checks++;
        if (ReadValid !== 1'b0 || ReadData1 !== 64'd0) begin
            errors++;
            $display("FAIL reset_midstream valid=%b rd1=%h expected 0 0", ReadValid, ReadData1);
        end
        do_read(5'd2, 5'd7);
        checks++;
        if (ReadData1 !== 64'd0 || ReadData2 !== 64'd0 || ReadValid !== 1'b1) begin
            errors++;
            $display("FAIL reset_clears rd1=%h rd2=%h valid=%b expected 0 0 1", ReadData1, ReadData2, ReadValid);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int n = 0; n < 400; n++) begin
            reset         = ($urandom_range(0, 49) == 0);
            RegWrite      = $urandom_range(0, 1) == 1;
            ReadEn        = $urandom_range(0, 3) != 0;
            // Small address window on most cycles to provoke same-address collisions.
            WriteRegister = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            ReadRegister1 = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            ReadRegister2 = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            WriteData     = {$urandom, $urandom};
            clk_edge();
            checks++;
            if (ReadData1 !== exp_rd1 || ReadData2 !== exp_rd2 || ReadValid !== exp_valid) begin
                errors++;
                if (bad < 10)
                    $display("FAIL random[%0d] rd1=%h rd2=%h valid=%b expected %h %h %b",
                             n, ReadData1, ReadData2, ReadValid, exp_rd1, exp_rd2, exp_valid);
                bad++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        test_reset();
        test_write_read();
        test_zero_reg();
        test_same_edge();
        test_hold();
        test_back_to_back();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
